// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer driving one external combinational BCD digit adder, LSD first.
// Latency DIGITS+1 cycles start->done (1 cycle on non-BCD operand); start is ignored while busy, nothing is queued.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   a,
  input  logic [4*DIGITS-1:0]   b,
  input  logic                  cin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   sum,
  output logic                  cout,
  output logic                  err,
  output logic [3:0]            dig_a,
  output logic [3:0]            dig_b,
  output logic                  dig_cin,
  input  logic [3:0]            dig_s,
  input  logic                  dig_carry
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [DIGITS-1:0][3:0] a_in;
  logic [DIGITS-1:0][3:0] b_in;
  logic [DIGITS-1:0][3:0] a_reg;
  logic [DIGITS-1:0][3:0] b_reg;
  logic [DIGITS-1:0][3:0] sum_reg;
  logic [IW-1:0]          idx;
  logic                   carry_reg;
  logic                   cout_reg;
  logic                   err_reg;
  logic                   bad_bcd;
  logic                   accept;
  logic                   last;

  assign a_in   = a;
  assign b_in   = b;
  assign accept = (state == IDLE) && start;
  assign last   = (idx == LAST_IDX);

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign err  = err_reg;

  // Operand validity is judged on the live inputs, in the same cycle they are latched.
  always_comb begin
    bad_bcd = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a_in[i] > 4'd9) || (b_in[i] > 4'd9)) begin
        bad_bcd = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    dig_a     = 4'd0;
    dig_b     = 4'd0;
    dig_cin   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = bad_bcd ? FIN : RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        dig_a   = a_reg[idx];
        dig_b   = b_reg[idx];
        dig_cin = carry_reg;
        if (last) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      idx       <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg     <= a_in;
        b_reg     <= b_in;
        carry_reg <= cin;
        idx       <= '0;
        sum_reg   <= '0;
        cout_reg  <= 1'b0;
        err_reg   <= bad_bcd;
      end else if (state == RUN) begin
        sum_reg[idx] <= dig_s;
        carry_reg    <= dig_carry;
        // Index stops at the top digit instead of wrapping.
        if (last) begin
          cout_reg <= dig_carry;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
